qpsk_demod: RTL and testbench
=============================

QPSK_DEMOD -- requirements
Module: qpsk_demod

Interface
REQ-001 SHALL have parameter SYMBOL_LEN, default 16: accepted samples per symbol; equals one carrier period of the LO table.
REQ-002 SHALL have parameter ACC_W, default 24: signed width of each correlation accumulator.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port qpsk_in, input, 10 bits signed: modulated sample stream.
REQ-006 SHALL have port in_valid, input, 1 bit: qpsk_in is accepted on an edge where in_valid=1.
REQ-007 SHALL have port sym_start, input, 1 bit: when in_valid=1, marks the accepted sample as sample 0 of a symbol.
REQ-008 SHALL have port i_bit, output, 1 bit: registered I decision.
REQ-009 SHALL have port q_bit, output, 1 bit: registered Q decision.
REQ-010 SHALL have port out_valid, output, 1 bit: single-cycle pulse, high when i_bit/q_bit hold a new decision.

Function
REQ-011 SHALL hold internal 16-entry signed 9-bit LO tables: cos[k]=round(255*cos(2*pi*k/16)) and sin[k]=round(255*sin(2*pi*k/16)), indexed by phase counter k.
REQ-012 SHALL implement states IDLE and RUN: IDLE->RUN on an accepted sample with sym_start=1; RUN persists until rst.
REQ-013 In IDLE, SHALL ignore accepted samples with sym_start=0.
REQ-014 Pipeline stage 1: on each accepted sample, SHALL register products qpsk_in*cos[k] and qpsk_in*sin[k] (19-bit signed, full precision) plus a last-sample flag.
REQ-015 Pipeline stage 2: SHALL sign-extend the products to ACC_W and add them into acc_i/acc_q; on sample 0, SHALL load the products instead of adding.
REQ-016 k and the sample counter SHALL advance only on accepted samples, SHALL wrap SYMBOL_LEN-1 -> 0, and SHALL hold during in_valid=0 gaps.
REQ-017 After the last sample, the next accepted sample SHALL start a new symbol at k=0 without needing sym_start.
REQ-018 Decision rule: i_bit=1 iff final acc_i>0, q_bit=1 iff final acc_q>0; a value of 0 SHALL decide 0.
REQ-019 i_bit, q_bit and out_valid SHALL update on the second rising edge after the edge accepting sample SYMBOL_LEN-1; out_valid SHALL be high for exactly one cycle.
REQ-020 i_bit and q_bit SHALL hold their values between out_valid pulses.
REQ-021 sym_start on an accepted sample while in RUN SHALL reset k and the sample counter to 0 and discard the partial symbol, with no out_valid for it; an out_valid already in the pipeline SHALL still be issued.
REQ-022 The bit mapping SHALL invert the modulator: (I,Q)=(1,1) for +cos+sin, (0,1) for -cos+sin, (0,0) for -cos-sin, (1,0) for +cos-sin.

Reset
REQ-023 rst=1 SHALL force state IDLE, k=0, sample counter=0, accumulators=0, pipeline valid=0, i_bit=0, q_bit=0, out_valid=0 (and i_soft=q_soft=0 when present).
REQ-024 rst asserted mid-symbol SHALL abort that symbol with no out_valid, including any pulse pending in the pipeline.

Configuration
REQ-025 With macro QPSK_DEMOD_SOFT_EN defined, SHALL add outputs i_soft and q_soft (8-bit signed): acc>>>12 saturated to [-128,127], updated together with i_bit/q_bit.
REQ-026 Without QPSK_DEMOD_SOFT_EN, the ports i_soft/q_soft and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-027 After reset, one symbol of 16 samples of cos[k]+sin[k] with sym_start on the first sample -> one out_valid pulse 2 cycles after the last accepted sample, i_bit=1, q_bit=1.
REQ-028 Four back-to-back symbols (-cos-sin, -cos+sin, cos+sin, cos-sin) with sym_start only on the first -> decisions 00, 01, 11, 10 in order, 16 accepted samples apart.
REQ-029 Same stimulus with in_valid=0 gaps of 1-3 cycles between samples -> identical decisions; no extra out_valid pulses.
REQ-030 Eight samples, then sym_start with a cos-sin symbol -> exactly one out_valid pulse, with i=1, q=0.
REQ-031 rst pulsed after sample 10 -> no out_valid pulse, and samples without sym_start are ignored until one arrives; an all-zero symbol -> i=0, q=0.
REQ-032 With QPSK_DEMOD_SOFT_EN defined, a full-scale cos+sin symbol -> i_soft=127, q_soft=127; a -cos-sin symbol -> i_soft=-128, q_soft=-128.

Source files
------------

// File: rtl/qpsk_demod.sv
// QPSK correlation demodulator: mixes each accepted sample with a 16-entry cos/sin LO,
// integrates over one symbol and slices the sign. Define QPSK_DEMOD_SOFT_EN for 8-bit soft outputs.
module qpsk_demod #(
  parameter int SYMBOL_LEN = 16,
  parameter int ACC_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [9:0] qpsk_in,
  input  logic              in_valid,
  input  logic              sym_start,
  output logic              i_bit,
  output logic              q_bit,
  output logic              out_valid
`ifdef QPSK_DEMOD_SOFT_EN
  ,
  output logic signed [7:0] i_soft,
  output logic signed [7:0] q_soft
`endif
);

  localparam int CNT_W = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // cos[k] = round(255*cos(2*pi*k/16)); sin[k] is the same table delayed by a quarter period
  function automatic logic signed [8:0] cos_lut(input logic [3:0] ph);
    logic signed [8:0] v;
    case (ph)
      4'd0:    v = 9'sd255;
      4'd1:    v = 9'sd236;
      4'd2:    v = 9'sd180;
      4'd3:    v = 9'sd98;
      4'd4:    v = 9'sd0;
      4'd5:    v = -9'sd98;
      4'd6:    v = -9'sd180;
      4'd7:    v = -9'sd236;
      4'd8:    v = -9'sd255;
      4'd9:    v = -9'sd236;
      4'd10:   v = -9'sd180;
      4'd11:   v = -9'sd98;
      4'd12:   v = 9'sd0;
      4'd13:   v = 9'sd98;
      4'd14:   v = 9'sd180;
      default: v = 9'sd236;
    endcase
    return v;
  endfunction

`ifdef QPSK_DEMOD_SOFT_EN
  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> 12;
    if ((&s[ACC_W-1:7]) || !(|s[ACC_W-1:7])) return s[7:0];
    else return s[ACC_W-1] ? 8'sh80 : 8'sh7f;
  endfunction
`endif

  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              k;
  logic                    s1_valid, s1_first, s1_last;
  logic signed [18:0]      p1_i, p1_q;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic                    dec_pend;

  logic                    accept;
  logic [CNT_W-1:0]        idx;
  logic [3:0]              ph;
  logic signed [18:0]      in_x, cos_x, sin_x;

  // sym_start always realigns the symbol, so it overrides the running counters
  assign accept = in_valid && ((state == RUN) || sym_start);
  assign idx    = sym_start ? '0 : cnt;
  assign ph     = sym_start ? 4'd0 : k;
  assign in_x   = {{9{qpsk_in[9]}}, qpsk_in};
  assign cos_x  = 19'(cos_lut(ph));
  assign sin_x  = 19'(cos_lut(ph - 4'd4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      p1_i      <= '0;
      p1_q      <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      dec_pend  <= 1'b0;
      i_bit     <= 1'b0;
      q_bit     <= 1'b0;
      out_valid <= 1'b0;
`ifdef QPSK_DEMOD_SOFT_EN
      i_soft    <= '0;
      q_soft    <= '0;
`endif
    end else begin
      s1_valid  <= accept;
      dec_pend  <= s1_valid && s1_last;
      out_valid <= dec_pend;

      if (accept) begin
        state    <= RUN;
        cnt      <= (idx == LAST) ? '0 : idx + 1'b1;
        k        <= (idx == LAST) ? 4'd0 : ph + 4'd1;
        s1_first <= (idx == '0);
        s1_last  <= (idx == LAST);
        p1_i     <= in_x * cos_x;
        p1_q     <= in_x * sin_x;
      end

      if (s1_valid) begin
        if (s1_first) begin
          acc_i <= {{(ACC_W-19){p1_i[18]}}, p1_i};
          acc_q <= {{(ACC_W-19){p1_q[18]}}, p1_q};
        end else begin
          acc_i <= acc_i + {{(ACC_W-19){p1_i[18]}}, p1_i};
          acc_q <= acc_q + {{(ACC_W-19){p1_q[18]}}, p1_q};
        end
      end

      // acc holds the completed symbol here; a following symbol's first load lands on the same edge
      if (dec_pend) begin
        i_bit  <= !acc_i[ACC_W-1] && (acc_i != '0);
        q_bit  <= !acc_q[ACC_W-1] && (acc_q != '0);
`ifdef QPSK_DEMOD_SOFT_EN
        i_soft <= sat8(acc_i);
        q_soft <= sat8(acc_q);
`endif
      end
    end
  end

endmodule

// File: tb/tb_qpsk_demod.sv
// Directed self-checking bench for qpsk_demod: symbol decisions, latency, gaps, restart and reset abort.
module tb_qpsk_demod;
  localparam int SYMBOL_LEN = 16;
  localparam int ACC_W      = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [9:0] qpsk_in;
  logic              in_valid;
  logic              sym_start;
  logic              i_bit, q_bit, out_valid;
`ifdef QPSK_DEMOD_SOFT_EN
  logic signed [7:0] i_soft, q_soft;
`endif

  qpsk_demod #(.SYMBOL_LEN(SYMBOL_LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .qpsk_in(qpsk_in), .in_valid(in_valid), .sym_start(sym_start),
    .i_bit(i_bit), .q_bit(q_bit), .out_valid(out_valid)
`ifdef QPSK_DEMOD_SOFT_EN
    , .i_soft(i_soft), .q_soft(q_soft)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int cos_t[16] = '{255, 236, 180, 98, 0, -98, -180, -236, -255, -236, -180, -98, 0, 98, 180, 236};
  int sin_t[16] = '{0, 98, 180, 236, 255, 236, 180, 98, 0, -98, -180, -236, -255, -236, -180, -98};

  // scoreboard: expected decisions {i,q} vs decisions seen at each out_valid
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int         obs_cyc_q[$];

  always @(negedge clk) begin
    if (out_valid) begin
      obs_q.push_back({i_bit, q_bit});
      obs_cyc_q.push_back(cyc);
    end
  end

  function automatic logic signed [9:0] samp(input int si, input int sq, input int k);
    int v;
    v = si * cos_t[k % 16] + sq * sin_t[k % 16];
    return 10'(v);
  endfunction

  // driver tasks
  task automatic send(input logic signed [9:0] v, input logic st);
    @(negedge clk);
    qpsk_in   = v;
    in_valid  = 1'b1;
    sym_start = st;
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    in_valid  = 1'b0;
    sym_start = 1'b0;
  endtask

  task automatic send_symbol(input int si, input int sq, input logic st, input int gap);
    for (int k = 0; k < SYMBOL_LEN; k++) begin
      send(samp(si, sq, k), st && (k == 0));
      if (gap > 0) repeat (1 + (k % gap)) @(posedge clk);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sym_start = 1'b0; qpsk_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (i_bit !== 1'b0) begin errors++; $display("FAIL reset_i_bit: got %b expected 0", i_bit); end
    checks++; if (q_bit !== 1'b0) begin errors++; $display("FAIL reset_q_bit: got %b expected 0", q_bit); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_sb();
    exp_q.push_back(2'b11);
    send_symbol(1, 1, 1'b1, 0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_iq: got %b expected %b", obs_q[0], exp_q[0]); end
      checks++; if (obs_cyc_q[0] - last_acc_cyc !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", obs_cyc_q[0] - last_acc_cyc); end
    end
    checks++; if ({i_bit, q_bit} !== 2'b11) begin errors++; $display("FAIL single_hold: got %b expected 11", {i_bit, q_bit}); end
  endtask

  task automatic run_four(input string name, input int gap);
    int si_v[4] = '{-1, -1, 1, 1};
    int sq_v[4] = '{-1, 1, 1, -1};
    clear_sb();
    exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b11); exp_q.push_back(2'b10);
    for (int s = 0; s < 4; s++) send_symbol(si_v[s], sq_v[s], s == 0, gap);
    repeat (6) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, obs_q.size(), exp_q.size()); end
    for (int n = 0; n < exp_q.size() && n < obs_q.size(); n++) begin
      checks++; if (obs_q[n] !== exp_q[n]) begin errors++; $display("FAIL %s_iq[%0d]: got %b expected %b", name, n, obs_q[n], exp_q[n]); end
      if (gap == 0 && n > 0) begin
        checks++; if (obs_cyc_q[n] - obs_cyc_q[n-1] !== SYMBOL_LEN) begin errors++; $display("FAIL %s_spacing[%0d]: got %0d expected %0d", name, n, obs_cyc_q[n] - obs_cyc_q[n-1], SYMBOL_LEN); end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_four("b2b", 0);
  endtask

  task automatic test_gaps();
    run_four("gaps", 3);
  endtask

  task automatic test_restart();
    clear_sb();
    exp_q.push_back(2'b10);
    for (int k = 0; k < 8; k++) send(samp(1, 1, k), 1'b0);
    send_symbol(1, -1, 1'b1, 0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL restart_count: got %0d expected 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL restart_iq: got %b expected %b", obs_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_rst_abort();
    clear_sb();
    // reset after sample 10
    for (int k = 0; k < 11; k++) send(samp(1, 1, k), k == 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    // reset while the final decision is still in the pipeline
    send_symbol(1, 1, 1'b1, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_count: got %0d expected 0", obs_q.size()); end
    checks++; if ({i_bit, q_bit} !== 2'b00) begin errors++; $display("FAIL abort_bits: got %b expected 00", {i_bit, q_bit}); end
    // in IDLE, a whole symbol without sym_start must be ignored
    send_symbol(1, 1, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL idle_ignore_count: got %0d expected 0", obs_q.size()); end
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    send_symbol(1, 1, 1'b1, 0);
    send_symbol(0, 0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL zero_count: got %0d expected 2", obs_q.size()); end
    for (int n = 0; n < 2 && n < obs_q.size(); n++) begin
      checks++; if (obs_q[n] !== exp_q[n]) begin errors++; $display("FAIL zero_iq[%0d]: got %b expected %b", n, obs_q[n], exp_q[n]); end
    end
  endtask

`ifdef QPSK_DEMOD_SOFT_EN
  task automatic test_soft();
    send_symbol(1, 1, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (i_soft !== 8'sd127) begin errors++; $display("FAIL soft_pos_i: got %0d expected 127", i_soft); end
    checks++; if (q_soft !== 8'sd127) begin errors++; $display("FAIL soft_pos_q: got %0d expected 127", q_soft); end
    send_symbol(-1, -1, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (i_soft !== -8'sd128) begin errors++; $display("FAIL soft_neg_i: got %0d expected -128", i_soft); end
    checks++; if (q_soft !== -8'sd128) begin errors++; $display("FAIL soft_neg_q: got %0d expected -128", q_soft); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_restart();
    test_rst_abort();
`ifdef QPSK_DEMOD_SOFT_EN
    test_soft();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
